// File: rtl/shake_pkg.sv
// -----------------------------------------------------------------------------
// shake_pkg
// Shared constants and types for the SHAKE squeeze block.
//   R               : default rate in bits (SHAKE128)
//   W               : default output word width in bits
//   WORDS_PER_BLOCK : output words carried by one permuted rate block
//   state_t         : squeeze FSM state encoding
//   idx_width()     : width of a counter addressing n entries (never 0)
// -----------------------------------------------------------------------------
package shake_pkg;

   localparam int R               = 1344;
   localparam int W               = 64;
   localparam int WORDS_PER_BLOCK = R / W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_BLOCK = 2'd1,
      STREAM     = 2'd2,
      FINISH     = 2'd3
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shake_squeeze_if.sv
// -----------------------------------------------------------------------------
// shake_squeeze_if
// Bundles the squeeze request, Keccak state hand-off and output stream.
//
// Handshakes:
//   - start/out_len : start is sampled only while the squeezer is idle.
//   - state_valid   : one-cycle pulse, state_rate is qualified by it.
//   - perm_req      : one-cycle pulse asking for the next permuted block.
//   - dout stream   : a word moves on every cycle where dout_valid and
//                     dout_ready are both high. While dout_valid is high and
//                     dout_ready is low, dout and dout_keep hold their value
//                     and dout_valid stays high. dout_valid never depends on
//                     dout_ready combinationally.
//
// master : consumer side (drives requests, state and ready)
// slave  : squeezer side
// -----------------------------------------------------------------------------
interface shake_squeeze_if #(
   parameter int R = shake_pkg::R,
   parameter int W = shake_pkg::W
);

   logic             start;
   logic [15:0]      out_len;
   logic [R-1:0]     state_rate;
   logic             state_valid;
   logic             perm_req;
   logic [W-1:0]     dout;
   logic [W/8-1:0]   dout_keep;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             done;

   modport master (
      output start, out_len, state_rate, state_valid, dout_ready,
      input  perm_req, dout, dout_keep, dout_valid, busy, done
   );

   modport slave (
      input  start, out_len, state_rate, state_valid, dout_ready,
      output perm_req, dout, dout_keep, dout_valid, busy, done
   );

endinterface

// File: rtl/squeeze_word_mux.sv
// -----------------------------------------------------------------------------
// squeeze_word_mux
// Combinational word select out of the buffered rate block, with byte-valid
// generation and zeroing of bytes that are not part of the request.
//   i_buf   : buffered rate block (bit i = message bit i)
//   i_idx   : word index inside the block
//   i_rem   : bytes still owed to the consumer
//   i_valid : output word is being presented
//   o_dout  : selected word, invalid bytes forced to 0
//   o_keep  : byte-valid mask, all zero when i_valid is low
// -----------------------------------------------------------------------------
module squeeze_word_mux #(
   parameter int R     = shake_pkg::R,
   parameter int W     = shake_pkg::W,
   parameter int IDX_W = shake_pkg::idx_width(R / W)
) (
   input  logic [R-1:0]     i_buf,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [15:0]      i_rem,
   input  logic             i_valid,
   output logic [W-1:0]     o_dout,
   output logic [W/8-1:0]   o_keep
);

   localparam int WPB = R / W;
   localparam int BPW = W / 8;

   logic [W-1:0] w_words [WPB];
   logic [W-1:0] w_word;

   for (genvar k = 0; k < WPB; k++) begin : g_words
      assign w_words[k] = i_buf[k*W +: W];
   end

   // Index is bounded by the FSM to WPB-1.
   assign w_word = w_words[i_idx];

   // Byte b is valid when more than b bytes remain; this yields all ones for
   // a full word and the low "remaining" bits for the final partial word.
   always_comb begin
      o_keep = '0;
      o_dout = '0;
      for (int b = 0; b < BPW; b++) begin
         o_keep[b] = i_valid && (i_rem > 16'(b));
         if (o_keep[b]) begin
            o_dout[8*b +: 8] = w_word[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/shake_squeeze.sv
// -----------------------------------------------------------------------------
// shake_squeeze
// SHAKE output stage: streams out_len bytes from successive permuted rate
// blocks, W bits per word, requesting a new permutation each time a block is
// exhausted and bytes are still owed.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : start/out_len request, state_rate/state_valid input,
//                  perm_req, dout/dout_keep/dout_valid/dout_ready stream,
//                  busy, done
//   o_dbg_state  : current FSM state
// -----------------------------------------------------------------------------
module shake_squeeze #(
   parameter int R = shake_pkg::R,
   parameter int W = shake_pkg::W
) (
   input  logic               clk,
   input  logic               rst_n,
   shake_squeeze_if.slave     bus,
   output shake_pkg::state_t  o_dbg_state
);

   localparam int WPB   = R / W;
   localparam int BPW   = W / 8;
   localparam int IDX_W = shake_pkg::idx_width(WPB);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);
   localparam logic [15:0]      BPW16    = 16'(BPW);

   shake_pkg::state_t r_state;
   logic [R-1:0]      r_buf;
   logic [IDX_W-1:0]  r_idx;
   logic [15:0]       r_rem;
   logic              r_perm_req;
   logic              r_dout_valid;
   logic              r_done;
   logic              r_busy;

   logic              w_xfer;
   logic [15:0]       w_take;
   logic [15:0]       w_rem_next;

   assign w_xfer     = r_dout_valid && bus.dout_ready;
   // Saturating take keeps the remaining counter from wrapping.
   assign w_take     = (r_rem >= BPW16) ? BPW16 : r_rem;
   assign w_rem_next = r_rem - w_take;

   // Buffer carries no reset: its contents are only observable through the
   // masked output path, which is zero whenever dout_valid is low.
   always_ff @(posedge clk) begin
      if (r_state == shake_pkg::WAIT_BLOCK && bus.state_valid) begin
         r_buf <= bus.state_rate;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= shake_pkg::IDLE;
         r_idx        <= '0;
         r_rem        <= '0;
         r_perm_req   <= 1'b0;
         r_dout_valid <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_perm_req <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            shake_pkg::IDLE: begin
               if (bus.start) begin
                  r_rem  <= bus.out_len;
                  r_idx  <= '0;
                  r_busy <= 1'b1;
                  if (bus.out_len == 16'd0) begin
                     r_state <= shake_pkg::FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= shake_pkg::WAIT_BLOCK;
                  end
               end
            end

            shake_pkg::WAIT_BLOCK: begin
               if (bus.state_valid) begin
                  r_idx        <= '0;
                  r_dout_valid <= 1'b1;
                  r_state      <= shake_pkg::STREAM;
               end
            end

            shake_pkg::STREAM: begin
               if (w_xfer) begin
                  r_rem <= w_rem_next;
                  r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                  if (w_rem_next == 16'd0) begin
                     // Request satisfied: finish even mid-block.
                     r_dout_valid <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= shake_pkg::FINISH;
                  end else if (r_idx == LAST_IDX) begin
                     r_dout_valid <= 1'b0;
                     r_perm_req   <= 1'b1;
                     r_state      <= shake_pkg::WAIT_BLOCK;
                  end
               end
            end

            shake_pkg::FINISH: begin
               r_busy  <= 1'b0;
               r_state <= shake_pkg::IDLE;
            end

            default: begin
               r_dout_valid <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= shake_pkg::IDLE;
            end
         endcase
      end
   end

   squeeze_word_mux #(
      .R     (R),
      .W     (W),
      .IDX_W (IDX_W)
   ) u_mux (
      .i_buf   (r_buf),
      .i_idx   (r_idx),
      .i_rem   (r_rem),
      .i_valid (r_dout_valid),
      .o_dout  (bus.dout),
      .o_keep  (bus.dout_keep)
   );

   assign bus.perm_req   = r_perm_req;
   assign bus.dout_valid = r_dout_valid;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign o_dbg_state    = r_state;

endmodule

// File: doc/shake_squeeze.md
SHAKE_SQUEEZE -- requirements
Module: shake_squeeze

Interface
REQ-001 The module SHALL have parameter R, default 1344, meaning the rate in bits (SHAKE128); R mod W = 0 is required.
REQ-002 The module SHALL have parameter W, default 64, meaning the output word width in bits; W is a multiple of 8.
REQ-003 The module SHALL use one clock, clk, input, 1 bit, with all state updated on its rising edge.
REQ-004 The module SHALL use one reset, rst_n, input, 1 bit, asynchronous and active-low.
REQ-005 start, input, 1 bit: request a squeeze of out_len bytes.
REQ-006 out_len, input, 16 bits: number of bytes requested; sampled on an accepted start.
REQ-007 state_rate, input, R bits: rate portion of the Keccak state, with bit i being message bit i, matching the absorb-side padding order.
REQ-008 state_valid, input, 1 bit: one-cycle pulse meaning state_rate holds a freshly permuted block.
REQ-009 perm_req, output, 1 bit: one-cycle pulse requesting another Keccak-f permutation.
REQ-010 dout, output, W bits: output word.
REQ-011 dout_keep, output, W/8 bits: byte-valid mask for dout.
REQ-012 dout_valid, output, 1 bit: dout holds a word.
REQ-013 dout_ready, input, 1 bit: the consumer accepts the word.
REQ-014 busy, output, 1 bit: high in every state except IDLE.
REQ-015 done, output, 1 bit: one-cycle pulse when the last byte has been accepted.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_BLOCK, STREAM and FINISH.
REQ-017 IDLE: start=1 SHALL capture out_len into the remaining-byte counter; next state is WAIT_BLOCK, or FINISH if out_len=0.
REQ-018 In any state other than IDLE, start SHALL be ignored.
REQ-019 WAIT_BLOCK: on state_valid=1, state_rate SHALL be registered into a local R-bit buffer, word_idx set to 0, and next state is STREAM.
REQ-020 In IDLE, STREAM and FINISH, state_valid SHALL be ignored.
REQ-021 Latency: state_valid in cycle t SHALL produce dout_valid=1 with word 0 in cycle t+1.
REQ-022 STREAM: dout_valid SHALL be 1 and dout SHALL equal buffer[W*word_idx +: W].
REQ-023 dout and dout_keep SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-024 dout_keep SHALL be all ones when remaining >= W/8; otherwise the lower "remaining" bits SHALL be 1, and dout bytes with keep=0 SHALL be forced to zero.
REQ-025 On a transfer (dout_valid and dout_ready), remaining SHALL decrement by min(remaining, W/8) and word_idx SHALL increment.
REQ-026 If a transfer leaves remaining=0, next state SHALL be FINISH, regardless of word_idx.
REQ-027 Otherwise, if the transfer was at word_idx=R/W-1, perm_req SHALL pulse in the following cycle and next state SHALL be WAIT_BLOCK; dout_valid SHALL be 0 there.
REQ-028 FINISH: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 The remaining counter SHALL never underflow, and word_idx SHALL never exceed R/W-1.

Reset
REQ-030 rst_n=0 SHALL force, asynchronously: state IDLE, remaining 0, word_idx 0, and outputs perm_req, dout_valid, done and busy to 0, with dout and dout_keep at 0.
REQ-031 Reset asserted mid-stream SHALL abandon the squeeze with no done pulse; after release the module SHALL accept a new start.
REQ-032 The buffer contents SHALL need no reset; dout SHALL be masked to 0 whenever dout_valid=0.

Structure
REQ-033 shake_pkg SHALL hold R, W, WORDS_PER_BLOCK (R/W) and the FSM state enum.
REQ-034 One sub-module is natural: squeeze_word_mux, which is combinational word select plus keep/zero masking from the buffer, word_idx and remaining.
REQ-035 Counters SHALL be sized from package constants: word_idx is clog2(WORDS_PER_BLOCK) bits and remaining is 16 bits.

Verification
REQ-036 out_len=32, ready held 1: exactly 4 words equal to state bits [255:0], all keep=8'hFF, no perm_req, done 1 cycle after the 4th transfer.
REQ-037 out_len=168: 21 full words, no perm_req, then done.
REQ-038 out_len=169: 21 words, then a perm_req pulse; after the next state_valid, 1 word with keep=8'h01, dout[63:8]=0, then done.
REQ-039 out_len=32, dout_ready low for 3 cycles on word 1: dout and keep stay stable, no word is skipped or duplicated, and total words = 4.
REQ-040 out_len=0: FINISH then done with no dout_valid and no perm_req.
REQ-041 Reset mid-stream then out_len=8 start: no stale done, and exactly 1 word is delivered from the new block.
